// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token table, 8-bit popcount and the
// transition-minimised word type passed from stage 1 to stage 2.
package tmds_pkg;

    typedef logic [8:0] qm_t;

    localparam logic [9:0] TOK_00 = 10'h354;
    localparam logic [9:0] TOK_01 = 10'h0AB;
    localparam logic [9:0] TOK_10 = 10'h154;
    localparam logic [9:0] TOK_11 = 10'h2AB;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        unique case (c)
            2'b00: t = TOK_00;
            2'b01: t = TOK_01;
            2'b10: t = TOK_10;
            2'b11: t = TOK_11;
            default: t = TOK_00;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Stage 1 of the TMDS encoder: transition-minimisation (XOR/XNOR chain)
// and the pipeline register carrying q_m, de and ctrl to stage 2.
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en_i,
    input  logic       de_i,
    input  logic [7:0] data_i,
    input  logic [1:0] ctrl_i,
    output qm_t        qm_o,
    output logic       de_o,
    output logic [1:0] ctrl_o,
    output logic       valid_o
);

    logic [3:0] ones;
    logic       use_xnor;
    qm_t        qm_d;
    qm_t        qm_q;
    logic       de_q;
    logic [1:0] ctrl_q;
    logic       valid_q;

    always_comb begin
        ones     = popcount8(data_i);
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !data_i[0]);
        qm_d     = '0;
        qm_d[0]  = data_i[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data_i[i]) : (qm_d[i-1] ^ data_i[i]);
        end
        qm_d[8] = ~use_xnor;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            qm_q    <= '0;
            de_q    <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= pix_en_i;
            if (pix_en_i) begin
                // Blanking data is don't-care; keep unknowns out of the register.
                qm_q   <= de_i ? qm_d : '0;
                de_q   <= de_i;
                ctrl_q <= ctrl_i;
            end
        end
    end

    assign qm_o    = qm_q;
    assign de_o    = de_q;
    assign ctrl_o  = ctrl_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/tmds_channel_encoder.sv
// TMDS 8b/10b channel encoder: stage 1 in tmds_qm_stage, stage 2 here selects
// inversion against the running disparity, or emits a control token in blanking.
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter int unsigned CNT_W    = 5,
    parameter logic [1:0]  RST_CTRL = 2'b00
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_en,
    input  logic                    de,
    input  logic [7:0]              data_in,
    input  logic [1:0]              ctrl,
    output logic [9:0]              tmds_out,
    output logic                    tmds_valid,
    output logic signed [CNT_W-1:0] disparity
);

    qm_t        s1_qm;
    logic       s1_de;
    logic [1:0] s1_ctrl;
    logic       s1_valid;

    tmds_qm_stage u_qm_stage (
        .clk      (clk),
        .rst      (rst),
        .pix_en_i (pix_en),
        .de_i     (de),
        .data_i   (data_in),
        .ctrl_i   (ctrl),
        .qm_o     (s1_qm),
        .de_o     (s1_de),
        .ctrl_o   (s1_ctrl),
        .valid_o  (s1_valid)
    );

    logic [3:0]              n1;
    logic                    q8;
    logic                    balanced;
    logic                    disp_neg;
    logic                    disp_pos;
    logic signed [CNT_W-1:0] bal;
    logic signed [CNT_W-1:0] qm8_x2;
    logic signed [CNT_W-1:0] nqm8_x2;
    logic signed [CNT_W-1:0] disp_d;
    logic signed [CNT_W-1:0] disp_q;
    logic [9:0]              tmds_d;
    logic [9:0]              tmds_q;
    logic                    valid_d;
    logic                    valid_q;

    assign n1       = popcount8(s1_qm[7:0]);
    assign q8       = s1_qm[8];
    assign balanced = (n1 == 4'd4);
    // n1 - n0 == 2*n1 - 8; modular wrap is harmless since the result fits CNT_W.
    assign bal      = $signed(CNT_W'({n1, 1'b0}) - CNT_W'(8));
    assign qm8_x2   = q8 ? CNT_W'(2) : '0;
    assign nqm8_x2  = q8 ? '0 : CNT_W'(2);
    assign disp_neg = disp_q[CNT_W-1];
    assign disp_pos = !disp_neg && (disp_q != '0);

    always_comb begin
        tmds_d  = tmds_q;
        disp_d  = disp_q;
        valid_d = 1'b0;
        if (s1_valid) begin
            valid_d = 1'b1;
            if (!s1_de) begin
                tmds_d = ctrl_token(s1_ctrl);
                disp_d = '0;
            end else if ((disp_q == '0) || balanced) begin
                tmds_d = {~q8, q8, q8 ? s1_qm[7:0] : ~s1_qm[7:0]};
                disp_d = q8 ? (disp_q + bal) : (disp_q - bal);
            end else if ((disp_pos && (n1 > 4'd4)) || (disp_neg && (n1 < 4'd4))) begin
                tmds_d = {1'b1, q8, ~s1_qm[7:0]};
                disp_d = disp_q + qm8_x2 - bal;
            end else begin
                tmds_d = {1'b0, q8, s1_qm[7:0]};
                disp_d = disp_q + bal - nqm8_x2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmds_q  <= ctrl_token(RST_CTRL);
            valid_q <= 1'b0;
            disp_q  <= '0;
        end else begin
            tmds_q  <= tmds_d;
            valid_q <= valid_d;
            disp_q  <= disp_d;
        end
    end

    assign tmds_out   = tmds_q;
    assign tmds_valid = valid_q;
    assign disparity  = disp_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Randomised bench for tmds_channel_encoder against a behavioural TMDS model,
// with directed reset, token and known-vector cases.
module tb_tmds_channel_encoder;

    logic              clk = 1'b0;
    logic              rst;
    logic              pix_en;
    logic              de;
    logic [7:0]        data_in;
    logic [1:0]        ctrl;
    logic [9:0]        tmds_out;
    logic              tmds_valid;
    logic signed [4:0] disparity;

    always #5 clk = ~clk;

    tmds_channel_encoder #(
        .CNT_W    (5),
        .RST_CTRL (2'b00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .de         (de),
        .data_in    (data_in),
        .ctrl       (ctrl),
        .tmds_out   (tmds_out),
        .tmds_valid (tmds_valid),
        .disparity  (disparity)
    );

    typedef struct {
        int         due;
        logic [9:0] sym;
        int         disp;
        logic       de;
        logic [7:0] data;
    } exp_t;

    exp_t       pend[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         ref_cnt  = 0;
    logic [9:0] last_out;
    logic [9:0] tok_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      tag, got, got, exp, exp, cyc);
    endtask

    // Encoder model: integer running count, spec rules applied directly.
    function automatic logic [9:0] ref_encode(input logic d_e, input logic [7:0] d,
                                              input logic [1:0] c);
        int         ones, n1, n0;
        logic       xn;
        logic [8:0] qm;
        logic [9:0] o;
        if (!d_e) begin
            ref_cnt = 0;
            return tok_tab[c];
        end
        ones  = $countones(d);
        xn    = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm    = '0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (ref_cnt == 0 || n1 == n0) begin
            o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            ref_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((ref_cnt > 0 && n1 > n0) || (ref_cnt < 0 && n0 > n1)) begin
            o = {1'b1, qm[8], ~qm[7:0]};
            ref_cnt += 2 * int'(qm[8]) + (n0 - n1);
        end else begin
            o = {1'b0, qm[8], qm[7:0]};
            ref_cnt += (n1 - n0) - 2 * int'(!qm[8]);
        end
        return o;
    endfunction

    // Receiver-side decode, used to show the symbol stream is invertible.
    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        logic [7:0] v, r;
        v    = s[9] ? ~s[7:0] : s[7:0];
        r[0] = v[0];
        for (int i = 1; i < 8; i++) r[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        return r;
    endfunction

    task automatic observe();
        int d;
        cyc++;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            check_eq("valid_pulse", int'(tmds_valid), 1);
            check_eq("symbol", int'(tmds_out), int'(pend[0].sym));
            check_eq("disparity", int'(disparity), pend[0].disp);
            if (pend[0].de) check_eq("decode", int'(ref_decode(tmds_out)), int'(pend[0].data));
            last_out = pend[0].sym;
            void'(pend.pop_front());
        end else begin
            check_eq("valid_idle", int'(tmds_valid), 0);
            check_eq("out_held", int'(tmds_out), int'(last_out));
        end
        d = int'(disparity);
        check_eq("disp_bound", int'(d <= 10 && d >= -10), 1);
    endtask

    task automatic cycle(input logic en, input logic d_e, input logic [7:0] d,
                         input logic [1:0] c);
        exp_t e;
        pix_en  = en;
        de      = d_e;
        data_in = d;
        ctrl    = c;
        if (en && !rst) begin
            e.due  = cyc + 2;
            e.de   = d_e;
            e.data = d;
            e.sym  = ref_encode(d_e, d, c);
            e.disp = ref_cnt;
            pend.push_back(e);
        end
        @(posedge clk);
        #1;
        observe();
    endtask

    task automatic idle();
        cycle(1'b0, 1'($urandom), 8'($urandom), 2'($urandom));
    endtask

    task automatic send(input logic d_e, input logic [7:0] d, input logic [1:0] c);
        cycle(1'b1, d_e, d, c);
        repeat (5) idle();
    endtask

    initial begin
        rst      = 1'b1;
        pix_en   = 1'b0;
        de       = 1'b0;
        data_in  = '0;
        ctrl     = '0;
        last_out = 10'h354;
        repeat (3) idle();
        check_eq("rst_out", int'(tmds_out), 'h354);
        check_eq("rst_valid", int'(tmds_valid), 0);
        check_eq("rst_disp", int'(disparity), 0);
        rst = 1'b0;
        repeat (2) idle();

        send(1'b1, 8'h00, 2'b00);
        check_eq("zero1_out", int'(tmds_out), 'h100);
        check_eq("zero1_disp", int'(disparity), -8);
        send(1'b1, 8'h00, 2'b00);
        check_eq("zero2_out", int'(tmds_out), 'h3FF);
        check_eq("zero2_disp", int'(disparity), 2);
        send(1'b1, 8'h00, 2'b00);
        check_eq("zero3_out", int'(tmds_out), 'h100);
        check_eq("zero3_disp", int'(disparity), -6);

        send(1'b0, 8'hxx, 2'b00);
        check_eq("blank_disp", int'(disparity), 0);
        send(1'b1, 8'hFF, 2'b00);
        check_eq("ones_out", int'(tmds_out), 'h200);
        check_eq("ones_disp", int'(disparity), -8);

        for (int c = 0; c < 4; c++) begin
            send(1'b1, 8'($urandom_range(1, 254)), 2'b00);
            send(1'b0, 8'hxx, 2'(c));
            check_eq("token_out", int'(tmds_out), int'(tok_tab[c]));
            check_eq("token_disp", int'(disparity), 0);
        end

        // Back-to-back strobes, mixing data and blanking.
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 1'(i % 7 != 3), 8'($urandom), 2'($urandom));
        end
        repeat (3) idle();

        // Asynchronous reset between edges drops the in-flight symbol.
        cycle(1'b1, 1'b1, 8'hA5, 2'b00);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_out", int'(tmds_out), 'h354);
        check_eq("arst_valid", int'(tmds_valid), 0);
        check_eq("arst_disp", int'(disparity), 0);
        pend.delete();
        ref_cnt  = 0;
        last_out = 10'h354;
        repeat (2) idle();
        rst = 1'b0;
        repeat (3) idle();

        for (int i = 0; i < 10000; i++) begin
            int gap;
            if ($urandom_range(0, 7) == 0) cycle(1'b1, 1'b0, 8'hxx, 2'($urandom));
            else cycle(1'b1, 1'b1, 8'($urandom), 2'($urandom));
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 5));
            repeat (gap) idle();
        end
        repeat (4) idle();
        check_eq("drained", pend.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
